// File: rtl/sub_result_pkg.sv
// Shared types and helpers for the sign/magnitude result display stage:
// FSM state encoding, active-low 7-segment patterns, and digit sizing.
package sub_result_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_e;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  // Smallest digit count d with 10^d > 2^n - 1 (at least one digit)
  function automatic int req_digits(input int n);
    longint unsigned maxv;
    longint unsigned p;
    int d;
    maxv = (64'd1 << n) - 64'd1;
    p    = 64'd1;
    d    = 0;
    for (int i = 0; i < 20; i++) begin
      if (p <= maxv) begin
        p = p * 64'd10;
        d++;
      end
    end
    if (d < 1) d = 1;
    return d;
  endfunction

  // BCD nibble to segment pattern; non-decimal codes show blank
  function automatic logic [6:0] seg7_enc(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Shift-add-3 correction for one BCD nibble: values >= 5 get +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3 (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  assign d_o = (d_i >= 4'd5) ? (d_i + 4'd3) : d_i;

endmodule

// File: rtl/sub_result_bcd.sv
// Result display stage: captures magnitude/sign on a valid/ready handshake,
// converts the magnitude to packed BCD one bit per clock (shift-add-3) and
// presents registered digits, sign and a one-cycle done pulse.
// Optional 7-segment outputs are built when SUB_RESULT_SEG7_EN is defined.
module sub_result_bcd
  import sub_result_pkg::*;
#(
  parameter int N      = 4,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N-1:0]          mag,
  input  logic                  neg,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  sign,
  output logic                  done
`ifdef SUB_RESULT_SEG7_EN
  ,
  output logic [7*DIGITS-1:0]   seg,
  output logic [6:0]            seg_sign
`endif
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = 4 * DIGITS;

  if (DIGITS < req_digits(N)) begin : g_bad_digits
    $error("sub_result_bcd: DIGITS too small to hold 2^N-1");
  end

  state_e          state_q, state_d;
  logic [BW-1:0]   work_q;      // BCD accumulator
  logic [N-1:0]    bin_q;       // binary bits still to shift in
  logic [CW-1:0]   cnt_q;
  logic            neg_q;       // already masked: never set for zero magnitude
  logic [BW-1:0]   adj;
  logic [BW-1:0]   shift_bcd;
  logic [N-1:0]    shift_bin;
  logic            accept;
  logic            last;

  assign accept = in_valid && in_ready;
  assign last   = (state_q == CONV) && (cnt_q == CW'(N - 1));

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .d_i (work_q[4*g +: 4]),
      .d_o (adj[4*g +: 4])
    );
  end

  assign {shift_bcd, shift_bin} = {adj, bin_q} << 1;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: IDLE waits for a handshake, CONV runs exactly N steps
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CONV;
      CONV:    if (last)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake output straight from state so the done cycle can accept
  always_comb begin
    in_ready = (state_q == IDLE);
  end

  // Conversion datapath: load on accept, add-3 then shift while converting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_q <= '0;
      bin_q  <= '0;
      cnt_q  <= '0;
      neg_q  <= 1'b0;
    end else if (accept) begin
      work_q <= '0;
      bin_q  <= mag;
      cnt_q  <= '0;
      neg_q  <= neg && (mag != '0);
    end else if (state_q == CONV) begin
      work_q <= shift_bcd;
      bin_q  <= shift_bin;
      cnt_q  <= cnt_q + CW'(1);
    end
  end

  // Visible result: updated only on the final step, so no partial digits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd  <= '0;
      sign <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= last;
      if (last) begin
        bcd  <= shift_bcd;
        sign <= neg_q;
      end
    end
  end

`ifdef SUB_RESULT_SEG7_EN
  logic [7*DIGITS-1:0] seg_d;
  logic                nz;

  // Segment patterns for the final digits with leading-zero blanking
  always_comb begin
    seg_d = '1;
    nz    = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      nz = nz | (shift_bcd[4*k +: 4] != 4'd0);
      if ((k == 0) || nz) seg_d[7*k +: 7] = seg7_enc(shift_bcd[4*k +: 4]);
    end
  end

  // Segment registers track bcd/sign on the same edge; blank out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg      <= '1;
      seg_sign <= SEG_BLANK;
    end else if (last) begin
      seg      <= seg_d;
      seg_sign <= neg_q ? SEG_MINUS : SEG_BLANK;
    end
  end
`endif

endmodule

// File: tb/tb_sub_result_bcd.sv
// Directed bench for sub_result_bcd: N=4/DIGITS=2 and N=8/DIGITS=3 instances.
module tb_sub_result_bcd;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        v4, n4, rdy4, sg4, dn4;
  logic [3:0]  m4;
  logic [7:0]  b4;
  logic        v8, n8, rdy8, sg8, dn8;
  logic [7:0]  m8;
  logic [11:0] b8;
`ifdef SUB_RESULT_SEG7_EN
  logic [13:0] seg4;
  logic [6:0]  ss4;
  logic [20:0] seg8;
  logic [6:0]  ss8;
`endif

  int total = 0;
  int bad   = 0;

  sub_result_bcd #(.N(4), .DIGITS(2)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(rdy4), .mag(m4), .neg(n4),
    .bcd(b4), .sign(sg4), .done(dn4)
`ifdef SUB_RESULT_SEG7_EN
    , .seg(seg4), .seg_sign(ss4)
`endif
  );

  sub_result_bcd #(.N(8), .DIGITS(3)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .mag(m8), .neg(n8),
    .bcd(b8), .sign(sg8), .done(dn8)
`ifdef SUB_RESULT_SEG7_EN
    , .seg(seg8), .seg_sign(ss8)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One accept, bounded wait for done, then result, latency and pulse checks
  task automatic conv(input bit sel, input logic [7:0] m, input logic n,
                      input logic [11:0] eb, input logic es, input string tag);
    int   lat;
    logic d;
    if (sel) begin v8 = 1'b1; m8 = m; n8 = n; end
    else     begin v4 = 1'b1; m4 = m[3:0]; n4 = n; end
    step();
    v4 = 1'b0; v8 = 1'b0;
    lat = 0; d = 1'b0;
    while (!d && lat < 20) begin
      step();
      lat++;
      d = sel ? dn8 : dn4;
    end
    chk({tag, "_lat"},  lat, sel ? 8 : 4);
    chk({tag, "_bcd"},  sel ? b8 : {4'h0, b4}, eb);
    chk({tag, "_sign"}, sel ? sg8 : sg4, es);
    step();
    chk({tag, "_pulse"}, sel ? dn8 : dn4, 1'b0);
    chk({tag, "_hold"},  sel ? b8 : {4'h0, b4}, eb);
  endtask

  initial begin
    rst = 1'b1;
    v4 = 1'b0; m4 = '0; n4 = 1'b0;
    v8 = 1'b0; m8 = '0; n8 = 1'b0;
    #12;
    chk("rst_bcd",   b4, 8'h00);
    chk("rst_sign",  sg4, 1'b0);
    chk("rst_done",  dn4, 1'b0);
    chk("rst_ready", rdy4, 1'b1);
    chk("rst_bcd8",  b8, 12'h000);
`ifdef SUB_RESULT_SEG7_EN
    chk("rst_seg",   seg4, 14'h3fff);
    chk("rst_sseg",  ss4, 7'h7f);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    step();

    // mag=15: busy for 4 cycles, no partial output, done after edge 4
    v4 = 1'b1; m4 = 4'd15; n4 = 1'b0;
    step();
    v4 = 1'b0; m4 = 4'd0;
    for (int e = 1; e <= 4; e++) begin
      chk("t15_busy",   rdy4, 1'b0);
      chk("t15_nodone", dn4, 1'b0);
      chk("t15_nopart", b4, 8'h00);
      step();
    end
    chk("t15_done",  dn4, 1'b1);
    chk("t15_bcd",   b4, 8'h15);
    chk("t15_sign",  sg4, 1'b0);
    chk("t15_ready", rdy4, 1'b1);
    step();
    chk("t15_pulse", dn4, 1'b0);

    conv(1'b0, 8'd9, 1'b1, 12'h009, 1'b1, "neg9");
    conv(1'b0, 8'd0, 1'b1, 12'h000, 1'b0, "negzero");

    // Back-to-back with in_valid held; mag changes during CONV ignored
    n4 = 1'b1; m4 = 4'd3; v4 = 1'b1;
    step();
    m4 = 4'd12;
    for (int e = 1; e <= 14; e++) begin
      step();
      if (e == 5)  m4 = 4'd7;
      if (e == 10) v4 = 1'b0;
      chk("b2b_done", dn4, (e == 4) || (e == 9) || (e == 14));
      if (e == 4)  begin chk("b2b_bcd3", b4, 8'h03); chk("b2b_rdy", rdy4, 1'b1); end
      if (e == 9)  chk("b2b_bcd12", b4, 8'h12);
      if (e == 14) begin chk("b2b_bcd7", b4, 8'h07); chk("b2b_sign", sg4, 1'b1); end
    end
    step();
    chk("b2b_end", dn4, 1'b0);

    // Reset mid-conversion aborts and clears the display
    v4 = 1'b1; m4 = 4'd14; n4 = 1'b0;
    step();
    v4 = 1'b0;
    step(); step();
    #2 rst = 1'b1;
    #1;
    chk("abort_bcd",  b4, 8'h00);
    chk("abort_sign", sg4, 1'b0);
    chk("abort_done", dn4, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_ready", rdy4, 1'b1);
    for (int e = 0; e < 6; e++) begin
      step();
      chk("abort_nodone", dn4, 1'b0);
    end
    conv(1'b0, 8'd6, 1'b0, 12'h006, 1'b0, "after_rst");

    conv(1'b1, 8'd255, 1'b0, 12'h255, 1'b0, "n8_255");
    conv(1'b1, 8'd100, 1'b1, 12'h100, 1'b1, "n8_100");

`ifdef SUB_RESULT_SEG7_EN
    conv(1'b0, 8'd1, 1'b1, 12'h001, 1'b1, "seg1");
    chk("seg_d0",   seg4[6:0],  7'b1111001);
    chk("seg_d1",   seg4[13:7], 7'b1111111);
    chk("seg_sign", ss4,        7'b0111111);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sub_result_bcd.md
Name: sub_result_bcd

Overview:
- Downstream stage of the N-bit sign/magnitude subtractor.
- Captures the subtractor's magnitude and sign on a valid/ready handshake.
- Converts the magnitude to packed BCD digits sequentially, one bit per clock (shift-add-3).
- Presents registered BCD digits plus a sign flag to the board's display/LED logic, with a one-cycle done pulse.

Parameters:
- N, 4, magnitude width; must match the subtractor's N.
- DIGITS, 2, number of BCD digits output; must satisfy 10^DIGITS > 2^N - 1; elaboration error otherwise.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  operand strobe from the subtractor's capture logic.
- in_ready  output  1  high when a new operand can be accepted.
- mag  input  N  unsigned magnitude (the subtractor's subtract output).
- neg  input  1  result-negative flag (the subtractor's neg output).
- bcd  output  4*DIGITS  packed BCD result; digit 0 in bits [3:0].
- sign  output  1  registered negative flag for the displayed result.
- done  output  1  one-cycle pulse marking new bcd/sign.

Behaviour:
- Reset (async, any state): state=IDLE; bcd=0, sign=0, done=0; internal shift/count registers cleared; in_ready=1 once released.
- States: IDLE, CONV.
- in_ready = (state==IDLE), combinational from state.
- Accept: rising edge with in_valid && in_ready.
  - Load shift register {DIGITS*4 zeros, mag}; latch neg; count=0; state->CONV.
- CONV, each edge:
  - Every BCD nibble >= 5 gets +3 (4-bit, no carry out of nibble).
  - Then the whole {bcd_work, bin_work} shifts left 1; count++.
- Edge with count==N-1 (the N-th step):
  - bcd <= final digits.
  - sign <= latched_neg && (mag_latched != 0); negative zero is never shown.
  - done <= 1; state->IDLE.
- done is 1 for exactly one cycle, the cycle after the final CONV edge.
- Latency: accept edge = edge 0; done high during the cycle after edge N.
- Throughput: one conversion per N+1 cycles. in_ready is already high in the done cycle, so back-to-back accepts are allowed.
- bcd/sign hold their last value until the next completion; they never show partial values.
- in_valid while in CONV: ignored, not queued; mag/neg changes during CONV have no effect.
- Reset mid-CONV: conversion aborted; no done pulse; bcd/sign cleared.
- mag=0: conversion still takes N steps; bcd=0.
- Max mag (2^N-1): exact result; no truncation, guaranteed by the DIGITS rule.

Optional Feature:
- Macro: SUB_RESULT_SEG7_EN.
- Defined:
  - Extra output seg [7*DIGITS-1:0], active-low {g,f,e,d,c,b,a} per digit, digit 0 in bits [6:0].
  - Extra output seg_sign [6:0]: segment g only lit (7'b0111111) when sign=1, else blank (7'b1111111).
  - Both registered, updated on the same edge as bcd; reset value all-ones (blank).
  - Leading-zero digits above digit 0 blanked.
  - Nibble values >9 cannot occur; if they do, output blank.
- Undefined: seg/seg_sign ports and logic absent; core behaviour identical.

Decomposition:
- Package sub_result_pkg:
  - state enum (IDLE, CONV).
  - 7-segment encoding constants for 0-9 and blank/minus patterns.
  - function returning the required DIGITS for a given N, used in the parameter check.
- Sub-module bcd_add3: 4-bit in -> 4-bit out, adds 3 when input >= 5. Instantiated DIGITS times via generate.

Test Plan:
- N=4, DIGITS=2: accept mag=15, neg=0 -> done on cycle 5 after accept edge; bcd=8'h15, sign=0; in_ready low for cycles 1-4.
- mag=9, neg=1 -> bcd=8'h09, sign=1; then mag=0, neg=1 -> bcd=8'h00, sign=0 (no negative zero).
- Hold in_valid high continuously with mag 3, 12, 7 -> three done pulses spaced 5 cycles apart; bcd 03, 12, 07 in order; mag changes during CONV ignored.
- Accept mag=14, assert rst at step 2 -> bcd=0, sign=0, no done, in_ready=1 after release; next accept mag=6 -> bcd=8'h06.
- N=8, DIGITS=3: mag=255 -> bcd=12'h255 after 9 cycles; mag=100 -> 12'h100.
- SUB_RESULT_SEG7_EN defined, N=4: mag=1, neg=1 -> seg digit0=7'b1111001, digit1 blank 7'b1111111, seg_sign=7'b0111111.
